frame_strobe_sequencer: RTL and testbench
=========================================

Name: frame_strobe_sequencer

Overview:
- Column-level configuration controller for a fabric column of terminal and logic tiles.
- Accepts frame words over a valid/ready stream and assembles one full frame across NumRows rows.
- Drives FrameData for the column, then pulses exactly one FrameStrobe line for the addressed frame.
- Sits between the configuration port and the column's FrameData/FrameStrobe inputs. Its FrameStrobe output feeds the bottom tile; the strobe then daisy-chains upward through each tile's FrameStrobe_O.

Parameters:
- MaxFramesPerCol, 20, number of FrameStrobe lines per column.
- FrameBitsPerRow, 32, FrameData width per tile row.
- NumRows, 16, tile rows per column; words per frame.
- StrobeCycles, 1, strobe high time in cycles (must be ≥1).

Ports:
- CLK  in  1  configuration clock; all state changes on the rising edge.
- resetn  in  1  reset, asynchronous and active-low.
- word_valid  in  1  word_data and frame_addr are valid.
- word_ready  out  1  block accepts a word this cycle.
- word_data  in  FrameBitsPerRow  frame word for the current row.
- frame_addr  in  5  frame index; sampled only with the first word of a frame.
- abort  in  1  synchronous abort of the current frame.
- clear_err  in  1  clears addr_err.
- FrameData  out  FrameBitsPerRow*NumRows  registered column frame data; row r occupies [r*FrameBitsPerRow +: FrameBitsPerRow].
- FrameStrobe  out  MaxFramesPerCol  registered one-hot or zero strobe.
- busy  out  1  state is not IDLE.
- frame_done  out  1  one-cycle pulse when a frame write completes.
- addr_err  out  1  sticky out-of-range address flag.

Behaviour:
- Reset (resetn low, asynchronous) forces:
  - state IDLE, row_cnt 0, strobe counter 0
  - FrameData 0, FrameStrobe 0, frame_done 0, addr_err 0
  - busy 0, word_ready 1 (after reset)
- Transfer: occurs when word_valid && word_ready on a clock edge.
- word_ready: combinational, 1 in IDLE and LOAD, 0 otherwise; never depends on word_valid.
- States:
  - IDLE: on a transfer, capture frame_addr, write the word into row 0, row_cnt←1, go to LOAD. If NumRows==1, go directly to CHECK.
  - LOAD: each transfer writes row row_cnt and increments row_cnt. On the transfer of row NumRows-1, go to CHECK. No timeout.
  - CHECK (1 cycle): if captured address < MaxFramesPerCol, go to SETUP. Otherwise set addr_err, pulse nothing, and return to IDLE. FrameData keeps the loaded words.
  - SETUP (1 cycle): FrameData stable, FrameStrobe 0; go to STROBE.
  - STROBE (StrobeCycles cycles): FrameStrobe[addr]=1, all other bits 0; then go to HOLD.
  - HOLD (1 cycle): FrameStrobe 0, FrameData unchanged, frame_done=1; then go to IDLE.
- Latency, with the last word accepted at edge T:
  - CHECK during T..T+1, SETUP T+1..T+2
  - strobe high from edge T+2 for StrobeCycles cycles
  - frame_done high for the one cycle after the strobe falls
  - next word is accepted no earlier than the edge that ends HOLD
- FrameData changes only during IDLE/LOAD transfers. It is never modified while FrameStrobe is nonzero or in SETUP/HOLD.
- FrameStrobe never has more than one bit set, and is never set outside STROBE.
- abort, sampled at an edge in any state:
  - next state IDLE, row_cnt 0, FrameStrobe 0 from that edge
  - no frame_done pulse
  - FrameData retained, addr_err unaffected
  - abort takes priority over a transfer in the same cycle; that word is discarded.
- clear_err: clears addr_err at the edge. If an error is set in the same cycle, set wins.
- Reset mid-STROBE drops FrameStrobe immediately (asynchronously).

Decomposition:
- Shared package cfg_frame_pkg holds:
  - state enum (IDLE, LOAD, CHECK, SETUP, STROBE, HOLD)
  - FRAME_ADDR_W = 5
  - default MaxFramesPerCol/FrameBitsPerRow constants reused by tile and fabric tops
- One natural sub-module, frame_row_loader: row_cnt plus row write-enable decode into the FrameData register.
- FSM, strobe counter and one-hot decode stay in the top.

Test Plan (NumRows=2, StrobeCycles=1, MaxFramesPerCol=20):
- Reset release, then words 0xAAAA5555 and 0x12345678 with addr 7 → FrameData = {0x12345678,0xAAAA5555}; FrameStrobe = 0x00080 for exactly 1 cycle, 2 cycles after the last transfer; frame_done pulses next cycle; busy 0 afterward.
- Addr 20 with two words → addr_err=1, FrameStrobe stays 0, no frame_done; clear_err → addr_err=0.
- word_valid held high back-to-back for two frames (addr 0, addr 19) → word_ready low during CHECK..HOLD; strobes 0x00001 then 0x80000, never overlapping; no word lost.
- abort asserted during STROBE with StrobeCycles=3 → FrameStrobe 0 the next cycle, no frame_done, next frame loads from row 0.
- resetn asserted low mid-LOAD after one word → all outputs 0 without a clock edge; a following frame loads cleanly.
- Random valid gaps in LOAD → rows written in order, one-hot invariant and "FrameData stable while strobe high" assertions hold.

Source files
------------

// File: rtl/frame_strobe_sequencer_pkg.sv
// Shared configuration-frame definitions: controller states, address width
// and default column geometry reused by the tile and fabric tops.
package cfg_frame_pkg;

  localparam int FRAME_ADDR_W       = 5;
  localparam int MAX_FRAMES_PER_COL = 20;
  localparam int FRAME_BITS_PER_ROW = 32;
  localparam int NUM_ROWS           = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CHECK  = 3'd2,
    ST_SETUP  = 3'd3,
    ST_STROBE = 3'd4,
    ST_HOLD   = 3'd5
  } frame_state_e;

  function automatic logic addr_in_range(input logic [FRAME_ADDR_W-1:0] addr,
                                         input int max_frames);
    return ({{(32-FRAME_ADDR_W){1'b0}}, addr} < 32'(max_frames));
  endfunction

endpackage

// File: rtl/frame_strobe_sequencer_if.sv
// Frame-word stream: valid/ready handshake carrying one row word plus the
// frame address that is sampled with the first word of each frame.
interface frame_strobe_sequencer_if #(
  parameter int W  = cfg_frame_pkg::FRAME_BITS_PER_ROW,
  parameter int AW = cfg_frame_pkg::FRAME_ADDR_W
);
  logic          word_valid;
  logic          word_ready;
  logic [W-1:0]  word_data;
  logic [AW-1:0] frame_addr;

  modport master (output word_valid, output word_data, output frame_addr, input  word_ready);
  modport slave  (input  word_valid, input  word_data, input  frame_addr, output word_ready);
endinterface

// File: rtl/frame_strobe_sequencer_row_loader.sv
// Row counter and per-row write decode into the column FrameData register.
// The counter wraps to 0 after the last row so the next frame starts at row 0.
module frame_row_loader #(
  parameter int W       = 32,
  parameter int NumRows = 16
) (
  input  logic               CLK,
  input  logic               resetn,
  input  logic               row_clr,
  input  logic               wr_en,
  input  logic [W-1:0]       word_data,
  output logic               last_row,
  output logic [W*NumRows-1:0] frame_data
);

  localparam int CNT_W = (NumRows > 1) ? $clog2(NumRows) : 1;

  logic [CNT_W-1:0]     row_cnt_r;
  logic [W*NumRows-1:0] frame_data_r;

  assign last_row   = (row_cnt_r == CNT_W'(NumRows - 1));
  assign frame_data = frame_data_r;

  // Row pointer: cleared by abort, advanced (with wrap) on every accepted word.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      row_cnt_r <= {CNT_W{1'b0}};
    end else if (row_clr) begin
      row_cnt_r <= {CNT_W{1'b0}};
    end else if (wr_en) begin
      row_cnt_r <= last_row ? {CNT_W{1'b0}} : row_cnt_r + CNT_W'(1);
    end
  end

  // Frame data storage: only the addressed row is written on an accepted word.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      frame_data_r <= {(W*NumRows){1'b0}};
    end else if (wr_en) begin
      for (int r = 0; r < NumRows; r++) begin
        if (row_cnt_r == CNT_W'(r)) begin
          frame_data_r[r*W +: W] <= word_data;
        end
      end
    end
  end

endmodule

// File: rtl/frame_strobe_sequencer.sv
// Column configuration controller: assembles a frame from NumRows stream words,
// then drives a single registered FrameStrobe pulse for the captured address.
module frame_strobe_sequencer
  import cfg_frame_pkg::*;
#(
  parameter int MaxFramesPerCol = MAX_FRAMES_PER_COL,
  parameter int FrameBitsPerRow = FRAME_BITS_PER_ROW,
  parameter int NumRows         = NUM_ROWS,
  parameter int StrobeCycles    = 1
) (
  input  logic                               CLK,
  input  logic                               resetn,
  frame_strobe_sequencer_if.slave            word_if,
  input  logic                               abort,
  input  logic                               clear_err,
  output logic [FrameBitsPerRow*NumRows-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0]         FrameStrobe,
  output logic                               busy,
  output logic                               frame_done,
  output logic                               addr_err
);

  localparam int STRB_W = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;

  frame_state_e              state_r, state_s;
  logic [FRAME_ADDR_W-1:0]   addr_r;
  logic [STRB_W-1:0]         strb_cnt_r;
  logic [MaxFramesPerCol-1:0] strobe_r, onehot_s;
  logic                      busy_r, frame_done_r, addr_err_r;
  logic                      word_ready_s, transfer_s, last_row_s, err_set_s;

  assign word_ready_s       = (state_r == ST_IDLE) || (state_r == ST_LOAD);
  assign word_if.word_ready = word_ready_s;
  // Abort discards a word offered in the same cycle.
  assign transfer_s         = word_if.word_valid && word_ready_s && !abort;

  assign FrameStrobe = strobe_r;
  assign busy        = busy_r;
  assign frame_done  = frame_done_r;
  assign addr_err    = addr_err_r;

  frame_row_loader #(.W(FrameBitsPerRow), .NumRows(NumRows)) u_loader (
    .CLK        (CLK),
    .resetn     (resetn),
    .row_clr    (abort),
    .wr_en      (transfer_s),
    .word_data  (word_if.word_data),
    .last_row   (last_row_s),
    .frame_data (FrameData)
  );

  // Next-state decode; abort overrides every state.
  always_comb begin
    state_s   = state_r;
    err_set_s = 1'b0;
    if (abort) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_LOAD: begin
          if (transfer_s) begin
            state_s = last_row_s ? ST_CHECK : ST_LOAD;
          end else begin
            state_s = state_r;
          end
        end
        ST_CHECK: begin
          if (addr_in_range(addr_r, MaxFramesPerCol)) begin
            state_s = ST_SETUP;
          end else begin
            err_set_s = 1'b1;
            state_s   = ST_IDLE;
          end
        end
        ST_SETUP:  state_s = ST_STROBE;
        ST_STROBE: begin
          if (strb_cnt_r == STRB_W'(StrobeCycles - 1)) begin
            state_s = ST_HOLD;
          end else begin
            state_s = ST_STROBE;
          end
        end
        ST_HOLD:   state_s = ST_IDLE;
        default:   state_s = ST_IDLE;
      endcase
    end
  end

  // One-hot decode of the captured frame address.
  always_comb begin
    onehot_s = {MaxFramesPerCol{1'b0}};
    for (int i = 0; i < MaxFramesPerCol; i++) begin
      onehot_s[i] = (addr_r == FRAME_ADDR_W'(i));
    end
  end

  // State, address capture, strobe timing and registered status outputs.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_r      <= ST_IDLE;
      addr_r       <= {FRAME_ADDR_W{1'b0}};
      strb_cnt_r   <= {STRB_W{1'b0}};
      strobe_r     <= {MaxFramesPerCol{1'b0}};
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      addr_err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      if ((state_r == ST_IDLE) && transfer_s) begin
        addr_r <= word_if.frame_addr;
      end
      strb_cnt_r   <= ((state_r == ST_STROBE) && (state_s == ST_STROBE))
                      ? strb_cnt_r + STRB_W'(1) : {STRB_W{1'b0}};
      strobe_r     <= (state_s == ST_STROBE) ? onehot_s : {MaxFramesPerCol{1'b0}};
      busy_r       <= (state_s != ST_IDLE);
      frame_done_r <= (state_s == ST_HOLD);
      // A newly detected error wins over a simultaneous clear.
      if (err_set_s) begin
        addr_err_r <= 1'b1;
      end else if (clear_err) begin
        addr_err_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frame_strobe_sequencer.sv
// Drives two sequencers (StrobeCycles 1 and 3) with shared stimulus and checks
// both every cycle against a timeline model derived from the frame rules.
module tb_frame_strobe_sequencer;
  import cfg_frame_pkg::*;

  localparam int W  = 32;
  localparam int NR = 2;
  localparam int MF = 20;

  logic CLK = 1'b0;
  logic resetn = 1'b0;
  logic abort = 1'b0;
  logic clear_err = 1'b0;
  logic v = 1'b0;
  logic [31:0] d = 32'd0;
  logic [4:0]  a = 5'd0;

  always #5 CLK = ~CLK;

  frame_strobe_sequencer_if #(.W(W)) if1 ();
  frame_strobe_sequencer_if #(.W(W)) if3 ();
  assign if1.word_valid = v;
  assign if1.word_data  = d;
  assign if1.frame_addr = a;
  assign if3.word_valid = v;
  assign if3.word_data  = d;
  assign if3.frame_addr = a;

  logic [W*NR-1:0] fd1, fd3;
  logic [MF-1:0]   fs1, fs3;
  logic busy1, busy3, done1, done3, err1, err3;

  frame_strobe_sequencer #(.MaxFramesPerCol(MF), .FrameBitsPerRow(W), .NumRows(NR), .StrobeCycles(1)) dut1 (
    .CLK(CLK), .resetn(resetn), .word_if(if1.slave), .abort(abort), .clear_err(clear_err),
    .FrameData(fd1), .FrameStrobe(fs1), .busy(busy1), .frame_done(done1), .addr_err(err1));

  frame_strobe_sequencer #(.MaxFramesPerCol(MF), .FrameBitsPerRow(W), .NumRows(NR), .StrobeCycles(3)) dut3 (
    .CLK(CLK), .resetn(resetn), .word_if(if3.slave), .abort(abort), .clear_err(clear_err),
    .FrameData(fd3), .FrameStrobe(fs3), .busy(busy3), .frame_done(done3), .addr_err(err3));

  // Reference model: post = cycles elapsed since the last word of a frame
  // (0 = accepting words); strobe window is post 3..2+sc, done at 3+sc.
  int          n_tests = 0;
  int          n_fail  = 0;
  int          post [2];
  int          k    [2];
  int          sc   [2];
  logic [4:0]  maddr[2];
  logic [31:0] mem  [2][NR];
  logic        merr [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      post[i] = 0; k[i] = 0; maddr[i] = 5'd0; merr[i] = 1'b0;
      for (int r = 0; r < NR; r++) mem[i][r] = 32'd0;
    end
  endtask

  task automatic model_edge(input int i);
    logic set_e;
    set_e = 1'b0;
    if (abort) begin
      post[i] = 0; k[i] = 0;
    end else if (post[i] == 0) begin
      if (v) begin
        mem[i][k[i]] = d;
        if (k[i] == 0) maddr[i] = a;
        k[i]++;
        if (k[i] == NR) begin k[i] = 0; post[i] = 1; end
      end
    end else if (post[i] == 1 && int'(maddr[i]) >= MF) begin
      set_e = 1'b1; post[i] = 0;
    end else if (post[i] == 3 + sc[i]) begin
      post[i] = 0;
    end else begin
      post[i]++;
    end
    if (set_e) merr[i] = 1'b1;
    else if (clear_err) merr[i] = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_one(input int i, input string p, input logic [63:0] fd, input logic [MF-1:0] fs,
                           input logic bsy, input logic dn, input logic er, input logic rdy);
    logic [MF-1:0] exp_fs;
    logic [63:0]   exp_fd;
    exp_fs = (post[i] >= 3 && post[i] <= 2 + sc[i]) ? (MF'(1) << maddr[i]) : {MF{1'b0}};
    exp_fd = {mem[i][1], mem[i][0]};
    chk({p, "_strobe"}, 64'(fs), 64'(exp_fs));
    chk({p, "_onehot0"}, 64'($countones(fs) <= 1), 64'd1);
    chk({p, "_framedata"}, fd, exp_fd);
    chk({p, "_busy"}, 64'(bsy), 64'(post[i] != 0 || k[i] != 0));
    chk({p, "_done"}, 64'(dn), 64'(post[i] == 3 + sc[i]));
    chk({p, "_addr_err"}, 64'(er), 64'(merr[i]));
    chk({p, "_ready"}, 64'(rdy), 64'(post[i] == 0));
  endtask

  task automatic check_all();
    check_one(0, "sc1", fd1, fs1, busy1, done1, err1, if1.word_ready);
    check_one(1, "sc3", fd3, fs3, busy3, done3, err3, if3.word_ready);
  endtask

  task automatic step(input logic vv, input logic [31:0] dd, input logic [4:0] aa,
                      input logic ab, input logic ce);
    v = vv; d = dd; a = aa; abort = ab; clear_err = ce;
    @(posedge CLK);
    model_edge(0);
    model_edge(1);
    @(negedge CLK);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    int guard;
    sc[0] = 1; sc[1] = 3;
    model_reset();

    // Reset state
    @(negedge CLK);
    check_all();
    @(negedge CLK);
    resetn = 1'b1;
    idle(1);

    // Basic frame to address 7
    step(1'b1, 32'hAAAA5555, 5'd7, 1'b0, 1'b0);
    step(1'b1, 32'h12345678, 5'd0, 1'b0, 1'b0);
    idle(7);
    chk("frame7_data", fd1, 64'h12345678_AAAA5555);

    // Out-of-range address, then clear
    step(1'b1, 32'h0BAD0001, 5'd20, 1'b0, 1'b0);
    step(1'b1, 32'h0BAD0002, 5'd20, 1'b0, 1'b0);
    idle(3);
    chk("err_set", 64'(err1), 64'd1);
    step(1'b0, 32'd0, 5'd0, 1'b0, 1'b1);
    chk("err_clear", 64'(err1), 64'd0);

    // Back-to-back frames with valid held high: addr 0 then addr 19
    for (int j = 0; j < 20; j++) step(1'b1, $urandom, (j < 6) ? 5'd0 : 5'd19, 1'b0, 1'b0);
    idle(8);

    // Abort in the middle of the 3-cycle strobe
    step(1'b1, 32'hCAFE0000, 5'd5, 1'b0, 1'b0);
    step(1'b1, 32'hCAFE0001, 5'd5, 1'b0, 1'b0);
    guard = 0;
    while (post[1] != 4 && guard < 10) begin
      idle(1);
      guard++;
    end
    chk("abort_reach_strobe", 64'(post[1]), 64'd4);
    step(1'b0, 32'd0, 5'd0, 1'b1, 1'b0);
    chk("abort_strobe_low", 64'(fs3), 64'd0);
    idle(2);
    step(1'b1, 32'h5A5A0000, 5'd3, 1'b0, 1'b0);
    step(1'b1, 32'h5A5A0001, 5'd3, 1'b0, 1'b0);
    idle(7);

    // Asynchronous reset mid-LOAD
    step(1'b1, 32'hDEADBEEF, 5'd9, 1'b0, 1'b0);
    #3;
    resetn = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge CLK);
    resetn = 1'b1;
    step(1'b1, 32'h11110000, 5'd2, 1'b0, 1'b0);
    step(1'b1, 32'h11110001, 5'd2, 1'b0, 1'b0);
    idle(7);

    // Randomized traffic with valid gaps, occasional abort and clear
    for (int j = 0; j < 400; j++) begin
      step(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 23)),
           1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 9) == 0));
    end
    idle(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
